// File: rtl/lvds_deser_align.sv
`default_nettype none
// ============================================================================
// Module   : lvds_deser_align
// Brief    : Multi-lane DDR deserializer that locks word boundaries to the
//            FCLK pattern and emits aligned parallel samples.
// Revision : 1.0
// ============================================================================
module lvds_deser_align #(
    parameter int NUM_CH         = 8,
    parameter int SAMPLE_BITS    = 12,
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int MSB_FIRST      = 1
) (
    input  logic                            bit_clk,
    input  logic                            reset_n,
    input  logic [NUM_CH-1:0]               data_h,
    input  logic [NUM_CH-1:0]               data_l,
    input  logic                            frame_h,
    input  logic                            frame_l,
    input  logic                            align_start,
    output logic [NUM_CH*SAMPLE_BITS-1:0]   data_out,
    output logic                            data_valid,
    output logic                            locked,
    output logic                            align_err,
    output logic                            bit_offset
);

    localparam int H    = SAMPLE_BITS / 2;
    localparam int SRW  = SAMPLE_BITS + 2;
    localparam int PH_W = $clog2(H);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int TO_W = $clog2(SEARCH_TIMEOUT + 1);

    localparam logic [PH_W-1:0]        PH_LAST   = PH_W'(H - 1);
    localparam logic [MC_W-1:0]        MC_LIM    = MC_W'(LOCK_COUNT);
    localparam logic [TO_W-1:0]        TO_LAST   = TO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SAMPLE_BITS-1:0] FRAME_PAT = {{H{1'b1}}, {H{1'b0}}};

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [NUM_CH-1:0][SRW-1:0]          sr_q;
    logic [SRW-1:0]                      fsr_q;
    logic [PH_W-1:0]                     ph_q, ph_d;
    logic [MC_W-1:0]                     mcnt_q, mcnt_d;
    logic [TO_W-1:0]                     tocnt_q, tocnt_d;
    logic                                err_q, err_d;
    logic                                off_q, off_d;
    logic [NUM_CH*SAMPLE_BITS-1:0]       dout_q, dout_d;
    logic                                dvalid_q, dvalid_d;

    logic [NUM_CH-1:0][SAMPLE_BITS-1:0]  lane_win;
    logic                                match0, match1, match_sel;
    logic [NUM_CH:0]                     unused_msbs;

    assign match0    = (fsr_q[SAMPLE_BITS-1:0] == FRAME_PAT);
    assign match1    = (fsr_q[SAMPLE_BITS:1]   == FRAME_PAT);
    assign match_sel = off_q ? match1 : match0;

    // The top shift-register bit only feeds history; no window reaches it.
    assign unused_msbs[NUM_CH] = fsr_q[SRW-1];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        logic [SAMPLE_BITS-1:0] win;
        assign win            = off_q ? sr_q[n][SAMPLE_BITS:1] : sr_q[n][SAMPLE_BITS-1:0];
        assign unused_msbs[n] = sr_q[n][SRW-1];
        if (MSB_FIRST != 0) begin : g_msb
            assign lane_win[n] = win;
        end else begin : g_lsb
            for (genvar b = 0; b < SAMPLE_BITS; b++) begin : g_bit
                assign lane_win[n][b] = win[SAMPLE_BITS-1-b];
            end
        end
    end

    always_ff @(posedge bit_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_SEARCH;
            sr_q     <= '0;
            fsr_q    <= '0;
            ph_q     <= '0;
            mcnt_q   <= '0;
            tocnt_q  <= '0;
            err_q    <= 1'b0;
            off_q    <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                sr_q[n] <= {sr_q[n][SAMPLE_BITS-1:0], data_l[n], data_h[n]};
            end
            fsr_q    <= {fsr_q[SAMPLE_BITS-1:0], frame_l, frame_h};
            state_q  <= state_d;
            ph_q     <= ph_d;
            mcnt_q   <= mcnt_d;
            tocnt_q  <= tocnt_d;
            err_q    <= err_d;
            off_q    <= off_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        mcnt_d   = mcnt_q;
        tocnt_d  = tocnt_q;
        err_d    = err_q;
        off_d    = off_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;

        if (align_start) begin
            state_d = ST_SEARCH;
            ph_d    = '0;
            mcnt_d  = '0;
            tocnt_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (match0 || match1) begin
                        // The matching cycle is phase 0, so the next one is phase 1.
                        off_d   = ~match0;
                        ph_d    = PH_W'(1);
                        mcnt_d  = MC_W'(1);
                        tocnt_d = '0;
                        state_d = ST_CONFIRM;
                    end else if (tocnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        tocnt_d = '0;
                    end else begin
                        tocnt_d = tocnt_q + 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (ph_q == '0) begin
                        if (!match_sel) begin
                            state_d = ST_SEARCH;
                            mcnt_d  = '0;
                            tocnt_d = '0;
                        end else if (mcnt_q == MC_LIM) begin
                            state_d = ST_LOCKED;
                        end else begin
                            mcnt_d = mcnt_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (ph_q == '0) begin
                        if (match_sel) begin
                            for (int n = 0; n < NUM_CH; n++) begin
                                dout_d[n*SAMPLE_BITS +: SAMPLE_BITS] = lane_win[n];
                            end
                            dvalid_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_SEARCH;
                            mcnt_d  = '0;
                            tocnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
    assign locked     = (state_q == ST_LOCKED);
    assign align_err  = err_q;
    assign bit_offset = off_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_deser_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_deser_align
// Brief    : Frame-level reference model driving two deserializer instances
//            (MSB-first and bit-reversed) from shared serial streams.
// Revision : 1.0
// ============================================================================
module tb_lvds_deser_align;

    localparam int SB   = 12;
    localparam int LC   = 4;
    localparam int ST   = 64;
    localparam int MAXB = 2048;
    localparam int MAXC = 1024;
    localparam int MAXF = 64;

    logic        bit_clk     = 1'b0;
    logic        reset_n     = 1'b0;
    logic [1:0]  data_h      = '0;
    logic [1:0]  data_l      = '0;
    logic        frame_h     = 1'b0;
    logic        frame_l     = 1'b0;
    logic        align_start = 1'b0;
    logic [23:0] dout1, dout2;
    logic        v1, v2, lk1, lk2, er1, er2, off1, off2;

    int checks = 0;
    int errors = 0;

    bit          fr_bit[MAXB];
    bit          d0_bit[MAXB];
    bit          d1_bit[MAXB];
    bit          ex_v[MAXC];
    bit          ex_lk[MAXC];
    bit          ex_err[MAXC];
    bit          as_cyc[MAXC];
    logic [11:0] ex_d0[MAXC];
    logic [11:0] ex_d1[MAXC];
    int          lk_ev[MAXC];
    int          err_ev[MAXC];
    bit          f_good[MAXF];
    bit          f_as[MAXF];
    logic [11:0] f_s0[MAXF];
    logic [11:0] f_s1[MAXF];
    int          nfr, ncyc, cur_dly;

    always #5 bit_clk = ~bit_clk;

    lvds_deser_align #(
        .NUM_CH(2), .SAMPLE_BITS(SB), .LOCK_COUNT(LC),
        .SEARCH_TIMEOUT(ST), .MSB_FIRST(1)
    ) dut (
        .bit_clk(bit_clk), .reset_n(reset_n), .data_h(data_h), .data_l(data_l),
        .frame_h(frame_h), .frame_l(frame_l), .align_start(align_start),
        .data_out(dout1), .data_valid(v1), .locked(lk1), .align_err(er1),
        .bit_offset(off1)
    );

    lvds_deser_align #(
        .NUM_CH(2), .SAMPLE_BITS(SB), .LOCK_COUNT(LC),
        .SEARCH_TIMEOUT(ST), .MSB_FIRST(0)
    ) dut_lsb (
        .bit_clk(bit_clk), .reset_n(reset_n), .data_h(data_h), .data_l(data_l),
        .frame_h(frame_h), .frame_l(frame_l), .align_start(align_start),
        .data_out(dout2), .data_valid(v2), .locked(lk2), .align_err(er2),
        .bit_offset(off2)
    );

    function automatic logic [11:0] rev12(input logic [11:0] x);
        logic [11:0] r;
        for (int b = 0; b < 12; b++) r[b] = x[11-b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout"},  dout1, 24'h0);
        chk({tag, "_valid"}, {23'h0, v1},   24'h0);
        chk({tag, "_locked"},{23'h0, lk1},  24'h0);
        chk({tag, "_err"},   {23'h0, er1},  24'h0);
        chk({tag, "_off"},   {23'h0, off1}, 24'h0);
        chk({tag, "_dout_lsb"},  dout2, 24'h0);
        chk({tag, "_valid_lsb"}, {23'h0, v2}, 24'h0);
    endtask

    // Serialise the frame table and derive per-cycle expectations at frame level:
    // a matching frame starts the count, frame m+LC locks, frames beyond emit data.
    task automatic build(input int lead_cyc, input int dly, input bit err_init, input bit tmo);
        int nb, mode, m, c, ci;
        bit lk, er;
        logic [11:0] pat;
        for (int i = 0; i < MAXB; i++) begin
            fr_bit[i] = 1'b0; d0_bit[i] = 1'b0; d1_bit[i] = 1'b0;
        end
        for (int i = 0; i < MAXC; i++) begin
            ex_v[i] = 1'b0; as_cyc[i] = 1'b0; ex_d0[i] = '0; ex_d1[i] = '0;
            lk_ev[i] = -1; err_ev[i] = -1;
        end
        cur_dly = dly;
        nb = lead_cyc * 2 + dly;
        for (int k = 0; k < nfr; k++) begin
            pat = f_good[k] ? 12'hFC0 : 12'hF80;
            for (int j = 0; j < 12; j++) begin
                fr_bit[nb] = pat[11-j];
                d0_bit[nb] = f_s0[k][11-j];
                d1_bit[nb] = f_s1[k][11-j];
                nb++;
            end
        end
        ncyc = (nfr == 0) ? lead_cyc : (nb + 1) / 2 + 3;
        mode = 0;
        m    = 0;
        for (int k = 0; k < nfr; k++) begin
            c  = (lead_cyc * 2 + dly + 12 * k + 11) / 2;
            ci = c + 1;
            if (f_as[k]) begin
                as_cyc[ci] = 1'b1; lk_ev[ci] = 0; err_ev[ci] = 0; mode = 0;
            end else if (mode == 0) begin
                if (f_good[k]) begin m = k; mode = 1; end
            end else if (mode == 1) begin
                if (!f_good[k]) mode = 0;
                else if (k == m + LC) begin mode = 2; lk_ev[ci] = 1; end
            end else begin
                if (f_good[k]) begin
                    ex_v[ci] = 1'b1; ex_d0[ci] = f_s0[k]; ex_d1[ci] = f_s1[k];
                end else begin
                    err_ev[ci] = 1; lk_ev[ci] = 0; mode = 0;
                end
            end
        end
        if (tmo) err_ev[ST-1] = 1;
        lk = 1'b0;
        er = err_init;
        for (int i = 0; i < ncyc; i++) begin
            if (lk_ev[i]  >= 0) lk = (lk_ev[i] == 1);
            if (err_ev[i] >= 0) er = (err_ev[i] == 1);
            ex_lk[i]  = lk;
            ex_err[i] = er;
        end
    endtask

    task automatic run_stream(input int upto);
        for (int i = 0; i < upto; i++) begin
            frame_l     = fr_bit[2*i];
            frame_h     = fr_bit[2*i+1];
            data_l      = {d1_bit[2*i],   d0_bit[2*i]};
            data_h      = {d1_bit[2*i+1], d0_bit[2*i+1]};
            align_start = as_cyc[i];
            @(posedge bit_clk);
            #1;
            chk($sformatf("valid c%0d", i),     {23'h0, v1},  {23'h0, ex_v[i]});
            chk($sformatf("valid_lsb c%0d", i), {23'h0, v2},  {23'h0, ex_v[i]});
            chk($sformatf("locked c%0d", i),    {23'h0, lk1}, {23'h0, ex_lk[i]});
            chk($sformatf("err c%0d", i),       {23'h0, er1}, {23'h0, ex_err[i]});
            if (ex_v[i]) begin
                chk($sformatf("lane0 c%0d", i), {12'h0, dout1[11:0]},  {12'h0, ex_d0[i]});
                chk($sformatf("lane1 c%0d", i), {12'h0, dout1[23:12]}, {12'h0, ex_d1[i]});
                chk($sformatf("lane0_lsb c%0d", i), {12'h0, dout2[11:0]},  {12'h0, rev12(ex_d0[i])});
                chk($sformatf("lane1_lsb c%0d", i), {12'h0, dout2[23:12]}, {12'h0, rev12(ex_d1[i])});
                chk($sformatf("offset c%0d", i), {23'h0, off1}, 24'(cur_dly));
                if (ex_d0[i] == 12'h001)
                    chk($sformatf("lsb_0x001 c%0d", i), {12'h0, dout2[11:0]}, 24'h800);
            end
        end
        align_start = 1'b0;
    endtask

    task automatic do_reset(input bit check, input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        if (check) check_zero(tag);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic frames_clear(input int n);
        nfr = n;
        for (int k = 0; k < MAXF; k++) begin
            f_good[k] = 1'b1; f_as[k] = 1'b0; f_s0[k] = '0; f_s1[k] = '0;
        end
    endtask

    task automatic frames_ramp(input int n);
        frames_clear(n);
        for (int k = 0; k < n; k++) begin
            f_s0[k] = 12'(k);
            f_s1[k] = 12'hA5C;
        end
    endtask

    initial begin
        int lead, v2idx, nv;

        #12;
        check_zero("reset");
        reset_n = 1'b1;

        // Nominal lock at offset 0, ramp on lane 0.
        lead = int'($urandom_range(8, 12));
        frames_ramp(14);
        build(lead, 0, 1'b0, 1'b0);
        run_stream(ncyc);

        // Same data delayed by one serial bit.
        do_reset(1'b0, "");
        frames_ramp(14);
        build(int'($urandom_range(8, 12)), 1, 1'b0, 1'b0);
        run_stream(ncyc);

        // Corrupted frame while locked, relock, then align_start clears the error.
        do_reset(1'b0, "");
        frames_clear(20);
        for (int k = 0; k < 20; k++) begin
            f_s0[k] = 12'(k + 100);
            f_s1[k] = 12'($urandom);
        end
        f_good[8] = 1'b0;
        f_as[17]  = 1'b1;
        build(int'($urandom_range(8, 12)), 0, 1'b0, 1'b0);
        run_stream(ncyc);

        // Dead frame lane: timeout error only.
        do_reset(1'b0, "");
        frames_clear(0);
        build(70, 0, 1'b0, 1'b1);
        run_stream(ncyc);

        // Asynchronous reset in the middle of LOCKED, then identical relock.
        do_reset(1'b0, "");
        frames_ramp(14);
        build(lead, 0, 1'b0, 1'b0);
        v2idx = 0;
        nv    = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (ex_v[i]) begin
                nv++;
                if (nv == 2) v2idx = i;
            end
        end
        run_stream(v2idx + 3);
        do_reset(1'b1, "midreset");
        run_stream(ncyc);

        // align_start coincident with a CONFIRM match restarts the count.
        do_reset(1'b0, "");
        frames_clear(16);
        for (int k = 0; k < 16; k++) begin
            f_s0[k] = 12'h001;
            f_s1[k] = 12'($urandom);
        end
        f_as[2] = 1'b1;
        build(int'($urandom_range(8, 12)), 0, 1'b0, 1'b0);
        run_stream(ncyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
